// File: rtl/warp_frame_scheduler.sv
// Run-level sequencer for the coordinate-warp generator: frame launch, gap, length check.
// Optional watchdog abort in RUN is built only when WARP_SCHED_WDT_EN is defined.
module warp_frame_scheduler #(
  parameter int ROW        = 4,
  parameter int COL        = 6,
  parameter int GAP_CYCLES = 8,
  parameter int WDT_CYCLES = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [CNT_W-1:0] cfg_frames,
  output logic             gen_start,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             busy,
  output logic             frame_done,
  output logic             run_done,
  output logic [CNT_W-1:0] frames_done,
  output logic             err_len,
  output logic             err_wdt
);

  localparam int N   = ROW * COL;
  localparam int BW  = $clog2(N) + 1;
  localparam int BW1 = BW + 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_GAP
  } state_t;

  state_t           state;
  logic [BW-1:0]    beat_cnt;
  logic [BW:0]      beat_nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] frames_nxt;
  logic [GW-1:0]    gap_cnt;
  logic             stop_pending;
  logic             stop_req;
  logic             sess_end;
  logic             beat;
  logic             wdt_hit;

  assign beat       = mon_tvalid & mon_tready;
  assign beat_nxt   = {1'b0, beat_cnt} + 1'b1;
  assign frames_nxt = frames_done + 1'b1;
  assign stop_req   = stop_pending | cmd_stop;
  assign sess_end   = stop_req |
                      ((target != '0) && (frames_nxt == target));

`ifdef WARP_SCHED_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES) + 1;

  logic [WW-1:0] wdt_cnt;

  assign wdt_hit = (state == S_RUN) && !beat &&
                   (wdt_cnt == WW'(WDT_CYCLES - 1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      wdt_cnt <= '0;
      err_wdt <= 1'b0;
    end else begin
      if (state == S_LAUNCH || beat)
        wdt_cnt <= '0;
      else if (state == S_RUN && !wdt_hit)
        wdt_cnt <= wdt_cnt + 1'b1;
      if (state == S_IDLE && cmd_start)
        err_wdt <= 1'b0;
      else if (wdt_hit)
        err_wdt <= 1'b1;
    end
  end
`else
  assign wdt_hit = 1'b0;
  assign err_wdt = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= S_IDLE;
      beat_cnt     <= '0;
      target       <= '0;
      gap_cnt      <= '0;
      stop_pending <= 1'b0;
      gen_start    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      run_done     <= 1'b0;
      frames_done  <= '0;
      err_len      <= 1'b0;
    end else begin
      gen_start  <= 1'b0;
      frame_done <= 1'b0;
      run_done   <= 1'b0;
      if (cmd_stop && state != S_IDLE)
        stop_pending <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (cmd_start) begin
            target       <= cfg_frames;
            frames_done  <= '0;
            err_len      <= 1'b0;
            stop_pending <= 1'b0;
            gen_start    <= 1'b1;
            busy         <= 1'b1;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          beat_cnt <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (beat && mon_tlast) begin
            if (beat_nxt != BW1'(N))
              err_len <= 1'b1;
            frames_done <= frames_nxt;
            frame_done  <= 1'b1;
            if (sess_end) begin
              run_done     <= 1'b1;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
              state        <= S_IDLE;
            end else if (GAP_CYCLES == 0) begin
              gen_start <= 1'b1;
              state     <= S_LAUNCH;
            end else begin
              gap_cnt <= GW'(GAP_CYCLES - 1);
              state   <= S_GAP;
            end
          end else if (beat) begin
            // Saturate so an overlong frame still reports a mismatch at tlast
            if (beat_cnt != BW'(N))
              beat_cnt <= beat_nxt[BW-1:0];
            if (beat_nxt == BW1'(N))
              err_len <= 1'b1;
          end else if (wdt_hit) begin
            run_done     <= 1'b1;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_GAP: begin
          if (stop_req) begin
            run_done     <= 1'b1;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
            state        <= S_IDLE;
          end else if (gap_cnt == '0) begin
            gen_start <= 1'b1;
            state     <= S_LAUNCH;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_frame_scheduler.sv
// Scoreboard bench for warp_frame_scheduler: frame/run completion events vs expected queue.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_warp_frame_scheduler;

  localparam int ROW = 4;
  localparam int COL = 6;
  localparam int NB  = ROW * COL;
  localparam int GAP = 8;
  localparam int WDT = 16;
  localparam int CW  = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cmd_start;
  logic          cmd_stop;
  logic [CW-1:0] cfg_frames;
  logic          gen_start;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          busy;
  logic          frame_done;
  logic          run_done;
  logic [CW-1:0] frames_done;
  logic          err_len;
  logic          err_wdt;

  typedef struct {
    bit fd;
    bit rd;
    int frames;
    bit el;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   gs_cnt = 0;

  warp_frame_scheduler #(
    .ROW(ROW), .COL(COL), .GAP_CYCLES(GAP),
    .WDT_CYCLES(WDT), .CNT_W(CW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_frames(cfg_frames), .gen_start(gen_start),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .busy(busy),
    .frame_done(frame_done), .run_done(run_done),
    .frames_done(frames_done), .err_len(err_len),
    .err_wdt(err_wdt)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin : monitor
    exp_t e;
    if (gen_start) gs_cnt++;
    if (frame_done || run_done) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected fd=%0b rd=%0b frames=%0d",
                 frame_done, run_done, frames_done);
      end else begin
        e = sb.pop_front();
        if (frame_done !== e.fd || run_done !== e.rd ||
            frames_done !== CW'(e.frames) || err_len !== e.el)
          $display("FAIL sb_event got fd=%0b rd=%0b fr=%0d el=%0b want fd=%0b rd=%0b fr=%0d el=%0b",
                   frame_done, run_done, frames_done, err_len,
                   e.fd, e.rd, e.frames, e.el);
        else passed++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic push(input bit fd, input bit rd, input int fr, input bit el);
    exp_t e;
    e.fd = fd; e.rd = rd; e.frames = fr; e.el = el;
    sb.push_back(e);
  endtask

  task automatic start(input int n);
    cfg_frames = CW'(n);
    cmd_start = 1'b1;
    @(negedge aclk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_gs(output int n);
    n = 0;
    while (!gen_start && n < 200) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (gen_start !== 1'b1)
      $display("FAIL gen_start_timeout waited=%0d want pulse", n);
    else passed++;
  endtask

  // Called on the LAUNCH cycle; streams nb handshaken beats in RUN
  task automatic beats(input int nb, input bit last, input bit bp,
                       input int stop_at);
    int k = 0;
    int i = 0;
    @(negedge aclk);
    while (k < nb && i < 2000) begin
      mon_tvalid = 1'b1;
      mon_tlast  = last && (k == nb - 1);
      mon_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_stop   = (i == stop_at);
      @(negedge aclk);
      if (mon_tready) k++;
      i++;
    end
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
    mon_tready = 1'b0;
    cmd_stop   = 1'b0;
  endtask

  task automatic frame(input int nb, input bit bp, input int stop_at,
                       output int n);
    wait_gs(n);
    beats(nb, 1'b1, bp, stop_at);
  endtask

  task automatic check_sb_empty(input string tag);
    checks++;
    if (sb.size() != 0)
      $display("FAIL %s pending_events=%0d want 0", tag, sb.size());
    else passed++;
  endtask

  task automatic do_reset;
    areset = 1'b1;
    cmd_start = 1'b0; cmd_stop = 1'b0; cfg_frames = '0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    cyc(2);
    areset = 1'b0;
    cyc(1);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({gen_start, busy, frame_done, run_done, err_len, err_wdt} !== 6'b0 ||
        frames_done !== '0)
      $display("FAIL %s outs=%b frames=%0d want all 0", tag,
               {gen_start, busy, frame_done, run_done, err_len, err_wdt},
               frames_done);
    else passed++;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    cmd_start = 1'b0; cmd_stop = 1'b0; cfg_frames = '0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    cyc(3);
    check_all_zero("reset_state");
    areset = 1'b0;
    cyc(1);
    cmd_stop = 1'b1;
    cyc(1);
    cmd_stop = 1'b0;
    cyc(1);
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_stop_ignored busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_single;
    int n;
    gs_cnt = 0;
    push(1, 1, 1, 0);
    start(1);
    checks++;
    if (busy !== 1'b1) $display("FAIL single_busy busy=%b want 1", busy);
    else passed++;
    frame(NB, 0, -1, n);
    cyc(4);
    checks++;
    if (gs_cnt !== 1 || busy !== 1'b0 || frames_done !== 16'd1 || err_len !== 1'b0)
      $display("FAIL single_end gs=%0d busy=%b fr=%0d el=%b want 1 0 1 0",
               gs_cnt, busy, frames_done, err_len);
    else passed++;
    check_sb_empty("single_sb");
  endtask

  task automatic test_multi_gap;
    int n;
    gs_cnt = 0;
    push(1, 0, 1, 0);
    push(1, 0, 2, 0);
    push(1, 1, 3, 0);
    start(3);
    for (int f = 0; f < 3; f++) begin
      frame(NB, 0, -1, n);
      // wait_gs starts one cycle after the tlast beat
      if (f > 0) begin
        checks++;
        if (n !== GAP)
          $display("FAIL gap_latency f=%0d got=%0d want=%0d", f, n + 1, GAP + 1);
        else passed++;
      end
    end
    cyc(12);
    checks++;
    if (gs_cnt !== 3 || frames_done !== 16'd3 || busy !== 1'b0)
      $display("FAIL multi_end gs=%0d fr=%0d busy=%b want 3 3 0",
               gs_cnt, frames_done, busy);
    else passed++;
    check_sb_empty("multi_sb");
  endtask

  task automatic test_backpressure;
    int n;
    push(1, 1, 1, 0);
    start(1);
    frame(NB, 1, -1, n);
    cyc(3);
    check_sb_empty("bp_sb");
  endtask

  task automatic test_len_err;
    int n;
    push(1, 0, 1, 1);
    push(1, 1, 2, 1);
    start(2);
    frame(20, 0, -1, n);
    frame(NB, 0, -1, n);
    cyc(3);
    start(1);
    checks++;
    if (err_len !== 1'b0) $display("FAIL len_clear err_len=%b want 0", err_len);
    else passed++;
    push(1, 1, 1, 1);
    frame(30, 0, -1, n);
    cyc(3);
    check_sb_empty("len_sb");
  endtask

  task automatic test_stop_unbounded;
    int n;
    gs_cnt = 0;
    push(1, 0, 1, 0);
    push(1, 1, 2, 0);
    start(0);
    frame(NB, 0, -1, n);
    frame(NB, 0, 10, n);
    cyc(20);
    checks++;
    if (gs_cnt !== 2 || busy !== 1'b0 || frames_done !== 16'd2)
      $display("FAIL stop_run gs=%0d busy=%b fr=%0d want 2 0 2",
               gs_cnt, busy, frames_done);
    else passed++;
    check_sb_empty("stop_sb");
  endtask

  task automatic test_stop_gap;
    int n;
    gs_cnt = 0;
    push(1, 0, 1, 0);
    start(0);
    frame(NB, 0, -1, n);
    push(0, 1, 1, 0);
    cmd_stop = 1'b1;
    @(negedge aclk);
    cmd_stop = 1'b0;
    checks++;
    if (run_done !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL stop_gap rd=%b fd=%b busy=%b want 1 0 0",
               run_done, frame_done, busy);
    else passed++;
    cyc(12);
    checks++;
    if (gs_cnt !== 1) $display("FAIL stop_gap_launch gs=%0d want 1", gs_cnt);
    else passed++;
    check_sb_empty("stop_gap_sb");
  endtask

  task automatic test_reset_mid;
    int n;
    push(1, 0, 1, 1);
    start(0);
    frame(20, 0, -1, n);
    wait_gs(n);
    beats(10, 1'b0, 1'b0, -1);
    areset = 1'b1;
    @(negedge aclk);
    check_all_zero("reset_mid");
    areset = 1'b0;
    cyc(3);
    check_sb_empty("reset_mid_sb");
  endtask

  task automatic test_wdt;
    int n;
`ifdef WARP_SCHED_WDT_EN
    push(0, 1, 0, 0);
    start(1);
    wait_gs(n);
    beats(5, 1'b0, 1'b0, -1);
    n = 0;
    while (!err_wdt && n < 100) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (err_wdt !== 1'b1 || n !== WDT || busy !== 1'b0 || frames_done !== '0)
      $display("FAIL wdt_abort ew=%b after=%0d busy=%b fr=%0d want 1 %0d 0 0",
               err_wdt, n, busy, frames_done, WDT);
    else passed++;
    cyc(3);
    check_sb_empty("wdt_sb");
`else
    start(1);
    wait_gs(n);
    beats(5, 1'b0, 1'b0, -1);
    cyc(3 * WDT);
    checks++;
    if (err_wdt !== 1'b0 || busy !== 1'b1)
      $display("FAIL wdt_absent ew=%b busy=%b want 0 1", err_wdt, busy);
    else passed++;
    do_reset();
    check_sb_empty("wdt_sb");
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_gap();
    test_backpressure();
    test_len_err();
    test_stop_unbounded();
    test_stop_gap();
    test_reset_mid();
    test_wdt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
